// File: rtl/nonce_report_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nonce_report_scheduler_pkg
// Description : Shared types and widths for the nonce report scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package nonce_report_scheduler_pkg;

   localparam int NONCE_W = 32;
   localparam int DROP_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SEND      = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_e;

endpackage
`default_nettype wire

// File: rtl/nonce_report_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. The search begins at the
//               index after last_grant and wraps modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] last_grant,
   output logic [$clog2(N)-1:0] grant_idx,
   output logic                 any_grant
);

   localparam int IDX_W = $clog2(N);

   // First requester found walking forward from last_grant+1 wins
   always_comb begin
      int cand;
      cand      = 0;
      grant_idx = '0;
      any_grant = 1'b0;
      for (int off = 1; off <= N; off++) begin
         cand = int'(last_grant) + off;
         if (cand >= N) begin
            cand = cand - N;
         end
         if (!any_grant && req[cand]) begin
            any_grant = 1'b1;
            grant_idx = IDX_W'(cand);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/nonce_report_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : nonce_report_scheduler
// Description : Buffers one golden nonce per core, arbitrates round-robin and
//               drives the serial transmitter send/busy handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module nonce_report_scheduler
   import nonce_report_scheduler_pkg::*;
#(
   parameter int NUM_CORES    = 4,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_CORES-1:0]         core_valid,
   input  logic [NONCE_W*NUM_CORES-1:0] core_nonce,
   input  logic                         new_work,
   input  logic                         tx_busy,
   output logic                         tx_send,
   output logic [NONCE_W-1:0]           tx_word,
   output logic [NUM_CORES-1:0]         pending,
   output logic [DROP_W-1:0]            drop_count
);

   localparam int IDX_W = $clog2(NUM_CORES);
   localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
   localparam int INC_W = $clog2(NUM_CORES + 2);
   localparam int SUM_W = DROP_W + INC_W + 1;

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     last_grant_q, last_grant_d;
   logic [NONCE_W-1:0]   slot_q [NUM_CORES];
   logic [NONCE_W-1:0]   slot_d [NUM_CORES];
   logic [NUM_CORES-1:0] full_q, full_d;
   logic                 tx_send_q, tx_send_d;
   logic [NONCE_W-1:0]   tx_word_q, tx_word_d;
   logic [DROP_W-1:0]    drop_q, drop_d;
   logic [TMO_W-1:0]     tmo_q, tmo_d;

   logic [IDX_W-1:0]     grant_idx;
   logic                 any_grant;
   logic                 grant_fire;
   logic                 timeout_fire;
   logic                 granted_i;
   logic [INC_W-1:0]     drop_inc;
   logic [SUM_W-1:0]     drop_sum;

   rr_arbiter #(
      .N (NUM_CORES)
   ) u_arb (
      .req        (full_q),
      .last_grant (last_grant_q),
      .grant_idx  (grant_idx),
      .any_grant  (any_grant)
   );

   // Handshake sequencer: grant in IDLE, pulse send, then track busy
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      tx_send_d    = 1'b0;
      tx_word_d    = tx_word_q;
      tmo_d        = '0;
      grant_fire   = 1'b0;
      timeout_fire = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A flush cycle never grants: the slots are being invalidated
            if (any_grant && !tx_busy && !new_work) begin
               grant_fire   = 1'b1;
               tx_word_d    = slot_q[grant_idx];
               last_grant_d = grant_idx;
               tx_send_d    = 1'b1;
               state_d      = ST_SEND;
            end
         end
         ST_SEND: begin
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = ST_WAIT_DONE;
            end else if (tmo_q == TMO_W'(BUSY_TIMEOUT - 1)) begin
               timeout_fire = 1'b1;
               state_d      = ST_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Slot capture/release and the number of nonces lost this cycle
   always_comb begin
      slot_d    = slot_q;
      full_d    = full_q;
      drop_inc  = '0;
      granted_i = 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
         granted_i = grant_fire && (grant_idx == IDX_W'(i));
         if (new_work) begin
            full_d[i] = 1'b0;
         end else begin
            if (granted_i) begin
               full_d[i] = 1'b0;
            end
            // A slot being granted this cycle frees up in time to take the new nonce
            if (core_valid[i]) begin
               if (!full_q[i] || granted_i) begin
                  slot_d[i] = core_nonce[NONCE_W*i +: NONCE_W];
                  full_d[i] = 1'b1;
               end else begin
                  drop_inc = drop_inc + 1'b1;
               end
            end
         end
      end
      if (timeout_fire) begin
         drop_inc = drop_inc + 1'b1;
      end
   end

   // Saturating drop counter
   always_comb begin
      drop_sum = SUM_W'(drop_q) + SUM_W'(drop_inc);
      if (drop_sum > SUM_W'({DROP_W{1'b1}})) begin
         drop_d = {DROP_W{1'b1}};
      end else begin
         drop_d = drop_sum[DROP_W-1:0];
      end
   end

   // Control state with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= IDX_W'(NUM_CORES - 1);
         full_q       <= '0;
         tx_send_q    <= 1'b0;
         tx_word_q    <= '0;
         drop_q       <= '0;
         tmo_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         full_q       <= full_d;
         tx_send_q    <= tx_send_d;
         tx_word_q    <= tx_word_d;
         drop_q       <= drop_d;
         tmo_q        <= tmo_d;
      end
   end

   // Slot payloads are only meaningful while their full flag is set
   always_ff @(posedge clk) begin
      slot_q <= slot_d;
   end

   assign tx_send    = tx_send_q;
   assign tx_word    = tx_word_q;
   assign pending    = full_q;
   assign drop_count = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_nonce_report_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_nonce_report_scheduler
// Description : Directed self-checking bench for nonce_report_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nonce_report_scheduler;

   localparam int NUM_CORES    = 4;
   localparam int BUSY_TIMEOUT = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   core_valid;
   logic [127:0] core_nonce;
   logic         new_work;
   logic         tx_busy;
   logic         tx_send;
   logic [31:0]  tx_word;
   logic [3:0]   pending;
   logic [7:0]   drop_count;

   always #5 clk = ~clk;

   nonce_report_scheduler #(
      .NUM_CORES    (NUM_CORES),
      .BUSY_TIMEOUT (BUSY_TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .core_valid (core_valid),
      .core_nonce (core_nonce),
      .new_work   (new_work),
      .tx_busy    (tx_busy),
      .tx_send    (tx_send),
      .tx_word    (tx_word),
      .pending    (pending),
      .drop_count (drop_count)
   );

   // Transmitter model: busy rises the cycle after send and lasts busy_len cycles
   logic model_on   = 1'b1;
   logic busy_force = 1'b0;
   int   busy_len   = 3;
   int   busy_left  = 0;

   always @(posedge clk) begin
      if (reset) busy_left <= 0;
      else if (model_on && tx_send) busy_left <= busy_len;
      else if (busy_left > 0) busy_left <= busy_left - 1;
   end

   assign tx_busy = (busy_left != 0) || busy_force;

   // Log every word handed to the transmitter
   logic [31:0] sent_q[$];
   int          send_cnt  = 0;
   int          consec    = 0;
   logic        prev_send = 1'b0;

   always @(negedge clk) begin
      if (tx_send) begin
         sent_q.push_back(tx_word);
         send_cnt++;
      end
      if (tx_send && prev_send) consec++;
      prev_send = tx_send;
   end

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [31:0] sent_at(input int k);
      if (k < sent_q.size()) return sent_q[k];
      return 32'hxxxxxxxx;
   endfunction

   task automatic wait_send(input string name, input int max, output int waited);
      waited = 0;
      while (tx_send !== 1'b1 && waited < max) begin
         tick();
         waited++;
      end
      if (tx_send !== 1'b1) begin
         n_total++;
         $display("FAIL %s: no tx_send within %0d cycles", name, max);
      end
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      core_valid = '0;
      new_work   = 1'b0;
      busy_force = 1'b0;
      model_on   = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      sent_q.delete();
   endtask

   typedef struct {
      int          core;
      logic [31:0] nonce;
      int          blen;
      logic [31:0] exp_word;
      logic [3:0]  exp_pend;
      int          exp_lat;
   } vec_t;

   vec_t vecs[3];

   initial begin
      int w;
      int base;
      int g;

      vecs[0] = '{core: 2, nonce: 32'hDEADBEEF, blen: 40, exp_word: 32'hDEADBEEF, exp_pend: 4'b0100, exp_lat: 2};
      vecs[1] = '{core: 0, nonce: 32'h12345678, blen: 3,  exp_word: 32'h12345678, exp_pend: 4'b0001, exp_lat: 2};
      vecs[2] = '{core: 3, nonce: 32'hCAFEF00D, blen: 1,  exp_word: 32'hCAFEF00D, exp_pend: 4'b1000, exp_lat: 2};

      core_nonce = '0;
      do_reset();
      chk("reset tx_send", tx_send, 0);
      chk("reset tx_word", tx_word, 0);
      chk("reset pending", pending, 0);
      chk("reset drop", drop_count, 0);

      // ---- single-nonce vectors ----
      for (int v = 0; v < 3; v++) begin
         busy_len = vecs[v].blen;
         base     = send_cnt;
         core_nonce = '0;
         core_nonce[32*vecs[v].core +: 32] = vecs[v].nonce;
         core_valid = 4'b0001 << vecs[v].core;
         tick();
         core_valid = '0;
         chk($sformatf("vec%0d pending set", v), pending, vecs[v].exp_pend);
         wait_send($sformatf("vec%0d send", v), 8, w);
         chk($sformatf("vec%0d latency", v), w + 1, vecs[v].exp_lat);
         chk($sformatf("vec%0d word", v), tx_word, vecs[v].exp_word);
         repeat (60) tick();
         chk($sformatf("vec%0d send count", v), send_cnt - base, 1);
         chk($sformatf("vec%0d pending clear", v), pending, 0);
         chk($sformatf("vec%0d drop", v), drop_count, 0);
      end

      // ---- fairness: all four at once, pointer at core 3 ----
      busy_len = 3;
      sent_q.delete();
      core_nonce = {32'h13, 32'h12, 32'h11, 32'h10};
      core_valid = 4'hF;
      tick();
      core_valid = '0;
      repeat (60) tick();
      chk("fair count", sent_q.size(), 4);
      for (int k = 0; k < 4; k++) chk($sformatf("fair order %0d", k), sent_at(k), 32'h10 + k);

      // pointer to core 0, then cores 0,1,3 request: 1, 3, 0 expected
      sent_q.delete();
      core_nonce = {32'h0, 32'h0, 32'h0, 32'h20};
      core_valid = 4'b0001;
      tick();
      core_valid = '0;
      repeat (20) tick();
      core_nonce = {32'h33, 32'h0, 32'h31, 32'h30};
      core_valid = 4'b1011;
      tick();
      core_valid = '0;
      repeat (60) tick();
      chk("wrap order 0", sent_at(0), 32'h20);
      chk("wrap order 1", sent_at(1), 32'h31);
      chk("wrap order 2", sent_at(2), 32'h33);
      chk("wrap order 3", sent_at(3), 32'h30);

      // ---- overflow ----
      do_reset();
      busy_force = 1'b1;
      core_nonce = '0;
      core_nonce[63:32] = 32'hA;
      core_valid = 4'b0010;
      tick();
      core_nonce[63:32] = 32'hB;
      tick();
      core_valid = '0;
      chk("ovf pending", pending, 4'b0010);
      chk("ovf drop", drop_count, 1);
      busy_force = 1'b0;
      repeat (30) tick();
      chk("ovf sent count", sent_q.size(), 1);
      chk("ovf sent word", sent_at(0), 32'hA);
      chk("ovf drop final", drop_count, 1);

      // ---- flush with a word in flight ----
      do_reset();
      busy_len = 10;
      core_nonce = '0;
      core_nonce[95:64] = 32'h55;
      core_valid = 4'b0100;
      tick();
      core_valid = '0;
      wait_send("flush send", 8, w);
      tick();
      tick();
      core_nonce = {32'h63, 32'h0, 32'h0, 32'h60};
      core_valid = 4'b1001;
      tick();
      core_valid = '0;
      chk("flush pre pending", pending, 4'b1001);
      core_nonce[63:32] = 32'h61;
      core_valid = 4'b0010;
      new_work   = 1'b1;
      tick();
      core_valid = '0;
      new_work   = 1'b0;
      chk("flush pending", pending, 0);
      repeat (30) tick();
      chk("flush sent count", sent_q.size(), 1);
      chk("flush sent word", sent_at(0), 32'h55);
      chk("flush drop", drop_count, 0);
      chk("flush pending final", pending, 0);

      // ---- busy timeout ----
      do_reset();
      model_on = 1'b0;
      core_nonce = {32'h0, 32'h72, 32'h71, 32'h0};
      core_valid = 4'b0110;
      tick();
      core_valid = '0;
      wait_send("tmo first send", 8, w);
      chk("tmo first word", tx_word, 32'h71);
      g = 0;
      do begin
         tick();
         g++;
      end while (tx_send !== 1'b1 && g < 40);
      chk("tmo gap", g, BUSY_TIMEOUT + 2);
      chk("tmo second word", tx_word, 32'h72);
      chk("tmo drop one", drop_count, 1);
      repeat (25) tick();
      chk("tmo drop two", drop_count, 2);
      chk("tmo pending", pending, 0);
      model_on = 1'b1;

      // ---- grant and capture on the same slot ----
      do_reset();
      busy_len = 3;
      core_nonce = '0;
      core_nonce[31:0] = 32'h80;
      core_valid = 4'b0001;
      tick();
      core_nonce[31:0] = 32'h81;
      tick();
      core_valid = '0;
      chk("same send", tx_send, 1);
      chk("same word", tx_word, 32'h80);
      chk("same pending", pending, 4'b0001);
      chk("same drop", drop_count, 0);
      repeat (30) tick();
      chk("same sent count", sent_q.size(), 2);
      chk("same second word", sent_at(1), 32'h81);
      chk("same pending final", pending, 0);

      // ---- reset in WAIT_DONE with slots pending ----
      do_reset();
      busy_len = 10;
      core_nonce = '0;
      core_nonce[63:32] = 32'h91;
      core_valid = 4'b0010;
      tick();
      core_valid = '0;
      wait_send("rst send", 8, w);
      tick();
      tick();
      core_nonce = {32'h0, 32'hA2, 32'h0, 32'hA0};
      core_valid = 4'b0101;
      tick();
      core_nonce[31:0] = 32'hA1;
      core_valid = 4'b0001;
      tick();
      core_valid = '0;
      chk("rst pre pending", pending, 4'b0101);
      chk("rst pre drop", drop_count, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst tx_send", tx_send, 0);
      chk("rst tx_word", tx_word, 0);
      chk("rst pending", pending, 0);
      chk("rst drop", drop_count, 0);
      base = send_cnt;
      repeat (10) tick();
      chk("rst no send", send_cnt - base, 0);

      chk("send never back-to-back", consec, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/nonce_report_scheduler.md
# nonce_report_scheduler

Shares the single serial result path among `NUM_CORES` hashing cores. It buffers one golden nonce per core, picks between pending cores round-robin, and sequences the byte-serialising transmitter's `send`/`busy` handshake so each 32-bit nonce goes out exactly once. It sits between the core array and the serial transmit block, and is driven by a new-work strobe from the serial receive side.

## Interface
Parameters:
- `NUM_CORES`, default 4: number of requesting cores, 2..16.
- `BUSY_TIMEOUT`, default 16: cycles to wait for `tx_busy` to rise after `tx_send` before abandoning the word.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `core_valid`, in, `NUM_CORES`: one-cycle strobe per core; golden nonce present.
- `core_nonce`, in, `32*NUM_CORES`: core i nonce at bits [32i+31:32i].
- `new_work`, in, 1: one-cycle strobe; new midstate/data loaded, pending nonces are stale.
- `tx_busy`, in, 1: transmitter busy.
- `tx_send`, out, 1: one-cycle send request to the transmitter.
- `tx_word`, out, 32: nonce to transmit; stable from `tx_send` until return to IDLE.
- `pending`, out, `NUM_CORES`: slot-full flags.
- `drop_count`, out, 8: saturating count of lost nonces.

## Operation
- Per-core slot: a 32-bit register plus a full flag.
  - `core_valid[i]` with the slot empty: capture the nonce, set full.
  - `core_valid[i]` with the slot full and not granted this cycle: discard the new nonce, `drop_count`++ (saturates at 255).
- FSM states: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
  - IDLE: if any slot is full and `tx_busy`=0, grant the round-robin winner. Load `tx_word` from the winner's slot, clear that flag, update the pointer, go to SEND.
  - SEND: `tx_send`=1 for exactly this cycle. Go to WAIT_BUSY.
  - WAIT_BUSY: on `tx_busy`=1, go to WAIT_DONE. After `BUSY_TIMEOUT` cycles without it, `drop_count`++ and go to IDLE.
  - WAIT_DONE: on `tx_busy`=0, go to IDLE.
- Round-robin arbitration:
  - The search starts at last_grant+1 mod `NUM_CORES`.
  - last_grant resets to `NUM_CORES`-1, so core 0 has first priority.
- Grant and capture on the same slot in the same cycle: the old value goes to `tx_word` and the new value is captured. The slot stays full and nothing is dropped.
- `new_work`:
  - Clears every full flag.
  - Any `core_valid` in the same cycle is discarded. This is not counted as a drop.
  - A word already in SEND/WAIT_* completes normally; it has already been latched by the transmitter.
  - No grant is made in IDLE during that cycle.
- Reset values: state IDLE, `tx_send`=0, `tx_word`=0, `pending`=0, `drop_count`=0, timeout counter 0.
- Reset mid-transfer: returns to IDLE immediately. Any byte already started by the transmitter is not tracked.

## Timing
- `core_valid` sampled at edge E0 → `pending` set after E0 → grant at E1 → `tx_send` high in the cycle after E1. Minimum latency is 2 cycles.
- The transmitter raises `busy` one cycle after `send`, so WAIT_BUSY normally lasts one cycle.
- Back-to-back words: IDLE is re-entered the cycle after `tx_busy` falls. The next `tx_send` follows 2 cycles after the fall.
- `tx_send` is registered and never high for two consecutive cycles.
- `tx_send` is never asserted while `tx_busy`=1 at grant time.
- Timeout counter: counts WAIT_BUSY cycles and clears on leaving WAIT_BUSY. The timeout fires when the count reaches `BUSY_TIMEOUT`-1.

## Structure
- Shared package holds:
  - The FSM state enum (2-bit).
  - `NONCE_W`=32.
  - `DROP_W`=8.
- Sub-module `rr_arbiter`:
  - Parameter `N`.
  - Inputs: request vector, last-grant index.
  - Outputs: grant index, any-grant.
  - Purely combinational.
- Slot registers, FSM, timeout counter and drop counter live in the top module.

## Test plan
- Single nonce: core 2 sends 0xDEADBEEF; transmitter model raises busy 1 cycle after send for 40 cycles → exactly one `tx_send`, `tx_word`=0xDEADBEEF, 2 cycles after `core_valid`, `pending`=0 afterwards.
- Fairness: all 4 cores strobe in the same cycle with nonces 0x10..0x13 → words sent in order 0x10, 0x11, 0x12, 0x13; next round starting at core 1 (pointer at core 0) is served core 1 first.
- Overflow: core 1 strobes 0xA then 0xB while its slot is full and the transmitter is busy → only 0xA is sent, `drop_count`=1.
- Flush: cores 0 and 3 pending with word 0x55 in WAIT_DONE, `new_work` pulsed together with `core_valid[1]` → 0x55 completes, no further `tx_send`, `pending`=0, `drop_count` unchanged.
- Timeout: transmitter model never raises busy → FSM returns to IDLE after `BUSY_TIMEOUT` WAIT_BUSY cycles, `drop_count`=1, next pending slot is granted.
- Reset mid-WAIT_DONE with slots pending → next cycle: IDLE, `tx_send`=0, `tx_word`=0, `pending`=0, `drop_count`=0.
